// File: rtl/tile_in_sequencer.sv
// Purpose : front end feeding the 1x1 PE tile; takes host rows on a ready/valid stream,
//           tags each row with block id, last, propagate toggle, dataflow, shift, bad_dataflow.
// Latency : one cycle from cmd handshake to tile_valid. Backpressure: none from the tile,
//           cmd_ready is high only while a configured block still has rows to take.
// Ports   : clk/rst (async, active-high); cfg_* block command with cfg_accept pulse;
//           cmd_valid/cmd_ready/cmd_a/b/d host rows; tile_* registered tile payload; busy.
module tile_in_sequencer #(
  parameter int A_W      = 8,
  parameter int ACC_W    = 20,
  parameter int ID_W     = 3,
  parameter int SHIFT_W  = 5,
  parameter int ROWS_W   = 4,
  parameter int GAP      = 1,
  parameter int ALLOW_WS = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_dataflow,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [ROWS_W-1:0]  cfg_rows,
  output logic               cfg_accept,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [A_W-1:0]     cmd_a,
  input  logic [ACC_W-1:0]   cmd_b,
  input  logic [ACC_W-1:0]   cmd_d,
  output logic               tile_valid,
  output logic [A_W-1:0]     tile_a,
  output logic [ACC_W-1:0]   tile_b,
  output logic [ACC_W-1:0]   tile_d,
  output logic [ID_W-1:0]    tile_id,
  output logic               tile_last,
  output logic               tile_dataflow,
  output logic               tile_propagate,
  output logic [SHIFT_W-1:0] tile_shift,
  output logic               tile_bad_dataflow,
  output logic               busy
);

  // Gap counter only ever needs to reach GAP; keep at least one bit.
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic                hs;
  logic [ID_W-1:0]     id_cnt;     // id the next accepted block will take
  logic [ID_W-1:0]     blk_id;     // id of the block in flight
  logic [ROWS_W-1:0]   rows_left;
  logic [GW-1:0]       gap_cnt;
  logic                cur_df;
  logic [SHIFT_W-1:0]  cur_shift;
  logic                prop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    hs        = 1'b0;
    case (state)
      S_IDLE: begin
        // A zero-row block would never produce a last row, so it is dropped outright.
        if (cfg_start && (cfg_rows != '0)) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          hs = 1'b1;
          if (rows_left == ROWS_W'(1))
            state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // cfg_start is sampled combinationally, so the pulse must be masked while in reset.
  assign cfg_accept = accept & ~rst;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_cnt            <= '0;
      blk_id            <= '0;
      rows_left         <= '0;
      gap_cnt           <= '0;
      cur_df            <= 1'b0;
      cur_shift         <= '0;
      prop_q            <= 1'b0;
      tile_valid        <= 1'b0;
      tile_a            <= '0;
      tile_b            <= '0;
      tile_d            <= '0;
      tile_id           <= '0;
      tile_last         <= 1'b0;
      tile_dataflow     <= 1'b0;
      tile_propagate    <= 1'b0;
      tile_shift        <= '0;
      tile_bad_dataflow <= 1'b0;
    end else begin
      if (accept) begin
        cur_df    <= cfg_dataflow;
        cur_shift <= cfg_shift;
        rows_left <= cfg_rows;
        prop_q    <= ~prop_q;
        blk_id    <= id_cnt;
        id_cnt    <= id_cnt + 1'b1;
      end

      gap_cnt    <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      tile_valid <= hs;

      // Payload and control only move on a handshake; idle cycles hold them.
      if (hs) begin
        rows_left         <= rows_left - 1'b1;
        tile_a            <= cmd_a;
        tile_b            <= cmd_b;
        tile_d            <= cmd_d;
        tile_id           <= blk_id;
        tile_last         <= (rows_left == ROWS_W'(1));
        tile_dataflow     <= cur_df;
        tile_shift        <= cur_shift;
        tile_propagate    <= prop_q;
        tile_bad_dataflow <= cur_df & (ALLOW_WS == 0);
      end
    end
  end

endmodule

// File: tb/tb_tile_in_sequencer.sv
module tb_tile_in_sequencer;
  localparam int A_W = 8, ACC_W = 20, ID_W = 3, SHIFT_W = 5, ROWS_W = 4, GAP = 1, ALLOW_WS = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               cfg_start, cfg_dataflow, cmd_valid;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [ROWS_W-1:0]  cfg_rows;
  logic [A_W-1:0]     cmd_a;
  logic [ACC_W-1:0]   cmd_b, cmd_d;

  logic               cfg_accept, cmd_ready, tile_valid, tile_last, tile_dataflow;
  logic               tile_propagate, tile_bad_dataflow, busy;
  logic [A_W-1:0]     tile_a;
  logic [ACC_W-1:0]   tile_b, tile_d;
  logic [ID_W-1:0]    tile_id;
  logic [SHIFT_W-1:0] tile_shift;

  logic               cfg_accept_ws, cmd_ready_ws, tile_valid_ws, tile_last_ws, tile_dataflow_ws;
  logic               tile_propagate_ws, tile_bad_dataflow_ws, busy_ws;
  logic [A_W-1:0]     tile_a_ws;
  logic [ACC_W-1:0]   tile_b_ws, tile_d_ws;
  logic [ID_W-1:0]    tile_id_ws;
  logic [SHIFT_W-1:0] tile_shift_ws;

  tile_in_sequencer #(.A_W(A_W), .ACC_W(ACC_W), .ID_W(ID_W), .SHIFT_W(SHIFT_W),
                      .ROWS_W(ROWS_W), .GAP(GAP), .ALLOW_WS(ALLOW_WS)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_dataflow(cfg_dataflow),
    .cfg_shift(cfg_shift), .cfg_rows(cfg_rows), .cfg_accept(cfg_accept),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
    .tile_valid(tile_valid), .tile_a(tile_a), .tile_b(tile_b), .tile_d(tile_d),
    .tile_id(tile_id), .tile_last(tile_last), .tile_dataflow(tile_dataflow),
    .tile_propagate(tile_propagate), .tile_shift(tile_shift),
    .tile_bad_dataflow(tile_bad_dataflow), .busy(busy));

  tile_in_sequencer #(.A_W(A_W), .ACC_W(ACC_W), .ID_W(ID_W), .SHIFT_W(SHIFT_W),
                      .ROWS_W(ROWS_W), .GAP(GAP), .ALLOW_WS(1)) dut_ws (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_dataflow(cfg_dataflow),
    .cfg_shift(cfg_shift), .cfg_rows(cfg_rows), .cfg_accept(cfg_accept_ws),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_ws), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
    .tile_valid(tile_valid_ws), .tile_a(tile_a_ws), .tile_b(tile_b_ws), .tile_d(tile_d_ws),
    .tile_id(tile_id_ws), .tile_last(tile_last_ws), .tile_dataflow(tile_dataflow_ws),
    .tile_propagate(tile_propagate_ws), .tile_shift(tile_shift_ws),
    .tile_bad_dataflow(tile_bad_dataflow_ws), .busy(busy_ws));

  int errors = 0;
  int checks = 0;

  // Reference model: block-level bookkeeping in plain integers.
  int n;            // cycle index
  int m_rows_rem;   // rows still owed by the open block (0 = none open)
  int m_idle_at;    // first cycle at which a new block may be accepted
  int m_blocks;     // blocks accepted since reset
  int m_df, m_sh;
  int e_tv, e_a, e_b, e_d, e_id, e_last, e_df, e_sh, e_prop, e_bad;

  typedef struct {
    int st, df, sh, rows, v, a;
    int acc, rdy, bsy, tv, ea, eid, elast, eprop;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mkv(int st, int df, int sh, int rows, int v, int a,
                               int acc, int rdy, int bsy, int tv, int ea, int eid,
                               int elast, int eprop);
    vec_t r;
    r.st = st; r.df = df; r.sh = sh; r.rows = rows; r.v = v; r.a = a;
    r.acc = acc; r.rdy = rdy; r.bsy = bsy; r.tv = tv; r.ea = ea; r.eid = eid;
    r.elast = elast; r.eprop = eprop;
    return r;
  endfunction

  function automatic int mk_b(int a);
    return (a * 37 + 1000) % (1 << ACC_W);
  endfunction

  function automatic int mk_d(int a);
    return ((a << 12) | 'hABC) % (1 << ACC_W);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    m_rows_rem = 0; m_idle_at = n; m_blocks = 0; m_df = 0; m_sh = 0;
    e_tv = 0; e_a = 0; e_b = 0; e_d = 0; e_id = 0; e_last = 0;
    e_df = 0; e_sh = 0; e_prop = 0; e_bad = 0;
  endtask

  task automatic check_regs();
    chk("tile_valid", tile_valid, e_tv);
    chk("tile_a", tile_a, e_a);
    chk("tile_b", tile_b, e_b);
    chk("tile_d", tile_d, e_d);
    chk("tile_id", tile_id, e_id);
    chk("tile_last", tile_last, e_last);
    chk("tile_dataflow", tile_dataflow, e_df);
    chk("tile_shift", tile_shift, e_sh);
    chk("tile_propagate", tile_propagate, e_prop);
    chk("tile_bad_dataflow", tile_bad_dataflow, e_bad);
    chk("ws_tile_valid", tile_valid_ws, e_tv);
    chk("ws_tile_id", tile_id_ws, e_id);
    chk("ws_bad_dataflow", tile_bad_dataflow_ws, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tile_valid"}, tile_valid, 0);
    chk({tag, "_tile_a"}, tile_a, 0);
    chk({tag, "_tile_b"}, tile_b, 0);
    chk({tag, "_tile_d"}, tile_d, 0);
    chk({tag, "_tile_id"}, tile_id, 0);
    chk({tag, "_tile_last"}, tile_last, 0);
    chk({tag, "_tile_dataflow"}, tile_dataflow, 0);
    chk({tag, "_tile_propagate"}, tile_propagate, 0);
    chk({tag, "_tile_shift"}, tile_shift, 0);
    chk({tag, "_tile_bad"}, tile_bad_dataflow, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_cfg_accept"}, cfg_accept, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One clock cycle: check what the last edge produced, drive new inputs,
  // check the combinational outputs, then advance the model across the edge.
  task automatic step(input int st, input int df, input int sh, input int rows,
                      input int v, input int a);
    int exp_rdy, exp_acc, exp_busy;
    @(negedge clk);
    check_regs();
    cfg_start    = st[0];
    cfg_dataflow = df[0];
    cfg_shift    = SHIFT_W'(sh);
    cfg_rows     = ROWS_W'(rows);
    cmd_valid    = v[0];
    cmd_a        = A_W'(a);
    cmd_b        = ACC_W'(mk_b(a));
    cmd_d        = ACC_W'(mk_d(a));
    #1;
    exp_rdy  = (m_rows_rem > 0);
    exp_acc  = (m_rows_rem == 0 && n >= m_idle_at && st != 0 && rows != 0);
    exp_busy = (m_rows_rem > 0 || n < m_idle_at);
    chk("cmd_ready", cmd_ready, exp_rdy);
    chk("cfg_accept", cfg_accept, exp_acc);
    chk("busy", busy, exp_busy);
    chk("ws_cmd_ready", cmd_ready_ws, exp_rdy);
    e_tv = 0;
    if (exp_acc != 0) begin
      m_blocks++;
      m_rows_rem = rows;
      m_df = df;
      m_sh = sh;
    end else if (exp_rdy != 0 && v != 0) begin
      e_tv   = 1;
      e_a    = a % (1 << A_W);
      e_b    = mk_b(a);
      e_d    = mk_d(a);
      e_id   = (m_blocks - 1) % (1 << ID_W);
      e_last = (m_rows_rem == 1);
      e_df   = m_df;
      e_sh   = m_sh;
      e_prop = m_blocks % 2;
      e_bad  = (m_df != 0 && ALLOW_WS == 0);
      m_rows_rem--;
      if (m_rows_rem == 0) m_idle_at = n + 1 + GAP;
    end
    n++;
  endtask

  initial begin
    n = 0;
    model_reset();
    // Each row: inputs, then outputs seen in that cycle (comb from these inputs,
    // tile_* from the previous edge).
    tbl[0]  = mkv(1,0,7,3, 0, 0,  1,0,0, 0, 0,0,0,0);
    tbl[1]  = mkv(0,0,0,0, 1, 1,  0,1,1, 0, 0,0,0,0);
    tbl[2]  = mkv(0,0,0,0, 1, 2,  0,1,1, 1, 1,0,0,1);
    tbl[3]  = mkv(0,0,0,0, 1, 3,  0,1,1, 1, 2,0,0,1);
    tbl[4]  = mkv(0,0,0,0, 0, 0,  0,0,1, 1, 3,0,1,1);
    tbl[5]  = mkv(1,0,3,2, 0, 0,  1,0,0, 0, 3,0,1,1);
    tbl[6]  = mkv(1,0,9,5, 1,10,  0,1,1, 0, 3,0,1,1);
    tbl[7]  = mkv(0,0,0,0, 0, 0,  0,1,1, 1,10,1,0,0);
    tbl[8]  = mkv(0,0,0,0, 0, 0,  0,1,1, 0,10,1,0,0);
    tbl[9]  = mkv(0,0,0,0, 1,11,  0,1,1, 0,10,1,0,0);
    tbl[10] = mkv(0,0,0,0, 0, 0,  0,0,1, 1,11,1,1,0);
    tbl[11] = mkv(0,0,0,0, 0, 0,  0,0,0, 0,11,1,1,0);

    rst = 1'b1;
    cfg_start = 1'b1; cfg_dataflow = 1'b0; cfg_shift = '0; cfg_rows = 4'd3;
    cmd_valid = 1'b1; cmd_a = '0; cmd_b = '0; cmd_d = '0;
    @(negedge clk); #1;
    check_zero("reset");
    @(negedge clk);
    cfg_start = 1'b0; cmd_valid = 1'b0; cfg_rows = '0;
    rst = 1'b0;
    model_reset();

    // Directed table: first two blocks, ignored mid-run cfg_start, 2-cycle stall.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].df, tbl[i].sh, tbl[i].rows, tbl[i].v, tbl[i].a);
      chk($sformatf("tbl%0d_accept", i), cfg_accept, tbl[i].acc);
      chk($sformatf("tbl%0d_ready", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_valid", i), tile_valid, tbl[i].tv);
      chk($sformatf("tbl%0d_a", i), tile_a, tbl[i].ea);
      chk($sformatf("tbl%0d_id", i), tile_id, tbl[i].eid);
      chk($sformatf("tbl%0d_last", i), tile_last, tbl[i].elast);
      chk($sformatf("tbl%0d_prop", i), tile_propagate, tbl[i].eprop);
    end

    // WS block: flagged on the ALLOW_WS=0 instance, clean on the other.
    step(1, 1, 4, 2, 0, 0);
    step(0, 0, 0, 0, 1, 50);
    step(0, 0, 0, 0, 1, 51);
    chk("ws_row0_bad", tile_bad_dataflow, 1);
    chk("ws_row0_bad_allowed", tile_bad_dataflow_ws, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("ws_row1_bad", tile_bad_dataflow, 1);
    chk("ws_row1_df", tile_dataflow, 1);
    step(0, 0, 0, 0, 0, 0);

    // Abort during the 2nd row of a 4-row block.
    step(1, 0, 2, 4, 0, 0);
    step(0, 0, 0, 0, 1, 21);
    step(0, 0, 0, 0, 1, 22);
    #1;
    rst = 1'b1;
    cfg_start = 1'b1; cfg_rows = 4'd2;
    #1;
    check_zero("abort");
    @(posedge clk);
    @(negedge clk);
    cfg_start = 1'b0; cmd_valid = 1'b0; cfg_rows = '0;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 1, 30);
    step(0, 0, 0, 0, 1, 31);
    chk("post_abort_ready", cmd_ready, 0);
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 40);
    step(0, 0, 0, 0, 0, 0);
    chk("post_abort_id", tile_id, 0);
    chk("post_abort_prop", tile_propagate, 1);
    step(0, 0, 0, 0, 0, 0);

    // Nine one-row blocks (the first already used id 0): ids wrap, propagate alternates,
    // and a zero-row request in between changes nothing.
    for (int i = 1; i < 10; i++) begin
      if (i == 4) step(1, 0, 0, 0, 0, 0);
      step(1, i % 2, i, 1, 0, 0);
      step(0, 0, 0, 0, 1, 60 + i);
      step(0, 0, 0, 0, 0, 0);
      chk($sformatf("blk%0d_id", i), tile_id, i % 8);
      chk($sformatf("blk%0d_prop", i), tile_propagate, (i + 1) % 2);
      chk($sformatf("blk%0d_last", i), tile_last, 1);
      step(0, 0, 0, 0, 0, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
           $urandom_range(0, 31), $urandom_range(0, 15),
           ($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 255));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_in_sequencer.md
Name: tile_in_sequencer

Overview:
- Transmitter-side front end for the HazardFlow-generated 1x1 PE tile.
- Accepts host rows (a, b, d) on a ready/valid stream plus a per-block configuration command.
- Drives the tile's valid-only input interface with registered data.
- Generates the control fields the tile consumes: id, last, propagate toggle, dataflow, shift and bad_dataflow.
- Sits between the mesh feeder/testbench driver and the tile input payload ports.

Parameters:
- A_W, 8, width of the a operand.
- ACC_W, 20, width of the b and d operands.
- ID_W, 3, width of the block id; wraps modulo 2^ID_W.
- SHIFT_W, 5, width of the shift field.
- ROWS_W, 4, width of the rows-per-block count.
- GAP, 1, idle cycles forced between the last row of one block and the first row of the next.
- ALLOW_WS, 0, 1 = weight-stationary dataflow legal; 0 = WS flagged as bad dataflow.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_start  in  1  begin-block request, single-cycle pulse.
- cfg_dataflow  in  1  0 = OS, 1 = WS.
- cfg_shift  in  SHIFT_W  shift for this block.
- cfg_rows  in  ROWS_W  rows in this block, 1..2^ROWS_W-1.
- cfg_accept  out  1  pulses when cfg_start is taken.
- cmd_valid  in  1  host row valid.
- cmd_ready  out  1  sequencer can take a row.
- cmd_a  in  A_W  row a operand.
- cmd_b  in  ACC_W  row b operand.
- cmd_d  in  ACC_W  row d operand.
- tile_valid  out  1  drives both input payload discriminants of the tile.
- tile_a  out  A_W  a payload.
- tile_b  out  ACC_W  b payload.
- tile_d  out  ACC_W  d payload.
- tile_id  out  ID_W  block id.
- tile_last  out  1  final row of block.
- tile_dataflow  out  1  dataflow discriminant.
- tile_propagate  out  1  propagate discriminant.
- tile_shift  out  SHIFT_W  shift.
- tile_bad_dataflow  out  1  illegal dataflow flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous and active-high. While asserted, all of the following are 0 and the FSM is in IDLE:
  - registers: tile_* (including tile_propagate), id counter, rows_left, gap counter, latched config;
  - outputs: cmd_ready, cfg_accept, busy.
- Assertion mid-block aborts immediately. Nothing is replayed after release.
- FSM states: IDLE, RUN, GAP.
- IDLE:
  - cmd_ready = 0.
  - A cfg_start with cfg_rows != 0 is accepted:
    - cfg_accept = 1 that cycle;
    - latch dataflow, shift, rows_left = cfg_rows;
    - toggle the propagate register;
    - id counter increments, except on the first block after reset, which uses id 0;
    - next state RUN.
  - A cfg_start with cfg_rows == 0 is ignored: no accept, no toggle, state unchanged.
- RUN:
  - cmd_ready = 1 (combinational from state).
  - On cmd_valid && cmd_ready, in the next cycle:
    - tile_valid = 1;
    - tile_a/b/d = cmd fields;
    - tile_id, tile_dataflow, tile_shift, tile_propagate = latched values;
    - tile_last = (rows_left == 1);
    - tile_bad_dataflow = (dataflow == 1) && (ALLOW_WS == 0).
  - rows_left decrements on every handshake.
  - The handshake with rows_left == 1 moves to GAP, or to IDLE when GAP == 0.
  - Cycles with no handshake produce tile_valid = 0.
- GAP:
  - cmd_ready = 0.
  - Counts GAP cycles, then moves to IDLE.
- cfg_start is ignored outside IDLE, including the cycle of the last handshake.
- The tile has no backpressure. At most one row is issued per cycle, and issue latency is exactly 1 cycle from handshake.
- When tile_valid = 0, the payload and control fields hold their last driven values. Only tile_valid returns low.
- Id wraps from 2^ID_W-1 to 0.
- busy = (state != IDLE).
- Width rules:
  - rows_left is ROWS_W bits and never underflows (guarded by the state).
  - The gap counter is ceil(log2(GAP+1)) bits, minimum 1.

Test Plan:
- Reset, then cfg_start with rows = 3, dataflow 0, shift 7; send rows a = 1, 2, 3 back-to-back -> tile_valid high for 3 consecutive cycles, each 1 cycle after its handshake; id 0, propagate 1, last only on a = 3; then busy drops after 1 GAP cycle.
- Second block, rows = 2 -> id 1, propagate 0. A cfg_start issued during RUN is ignored (cfg_accept stays 0).
- cmd_valid held low for 2 cycles mid-block -> tile_valid low for those cycles, payload held, rows_left unchanged, last still lands on the final row.
- cfg_dataflow = 1 with ALLOW_WS = 0 -> tile_bad_dataflow = 1 on every row of that block; with ALLOW_WS = 1 -> 0.
- 9 blocks of 1 row each -> ids 0..7 then 0; propagate alternates every block; cfg_rows = 0 produces no accept and no toggle.
- Assert rst during the 2nd row of a 4-row block -> all outputs 0 asynchronously; after release cmd_ready = 0 until a new cfg_start, and the next block uses id 0, propagate 1.
